// File: rtl/switch_input_loader_if.sv
// Downstream valid/ready stream carrying captured switch values to the sorter.
// The loader drives valid/data/last; the consumer drives ready.
interface switch_input_loader_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/switch_input_loader.sv
// Debounced pushbutton loader: captures DEPTH switch values, then streams them in order.
// Define LOADER_DEBOUNCE_EN to enable the counter debouncer; otherwise the synced button is used raw.
module switch_input_loader #(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_btn,
  input  logic [DATA_W-1:0]          switches,
  input  logic                       clear,
  switch_input_loader_if.master      out_if,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       busy
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

  typedef enum logic {StFill, StStream} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_q, wr_d;
  logic [PtrW-1:0]   rd_q, rd_d;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic btn_meta_q, btn_s_q;
  logic level_q, level_d;
  logic press_q;

  // Two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      btn_meta_q <= load_btn;
      btn_s_q    <= btn_meta_q;
    end
  end

`ifdef LOADER_DEBOUNCE_EN
  localparam int unsigned   DbW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (btn_s_q != level_q) begin
      if (db_cnt_q == DbLast) begin
        level_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  assign level_d = btn_s_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      level_q <= level_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign busy  = (state_q == StStream);
  assign full  = (count_q == DepthC);
  assign count = count_q;

  assign out_if.out_valid = busy;
  assign out_if.out_last  = busy && (rd_q == LastIdx);
  assign out_if.out_data  = busy ? mem_q[rd_q] : '0;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_we  = 1'b0;
    if (clear) begin
      state_d = StFill;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (press_q && (count_q < DepthC)) begin
            mem_we  = 1'b1;
            wr_d    = wr_q + 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == DepthC - 1'b1) begin
              state_d = StStream;
              wr_d    = '0;
              rd_d    = '0;
            end
          end
        end
        StStream: begin
          // Presses in this state are dropped by construction.
          if (out_if.out_ready) begin
            if (rd_q == LastIdx) begin
              state_d = StFill;
              count_d = '0;
              wr_d    = '0;
              rd_d    = '0;
            end else begin
              rd_d = rd_q + 1'b1;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Capture storage is intentionally not reset or cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_q] <= switches;
    end
  end

endmodule
